spi_master_ctrl: RTL and testbench

- Parametrised SPI master with an Avalon-MM slave register interface.
- Generalises the earlier register-only SPI block: a real shift engine, programmable SCLK divider, CPOL/CPHA modes, configurable word width and multiple slave selects.
- Sits on the system Avalon bus; software loads TX data, selects a slave, starts a transfer, then polls status and reads RX data.

---
 rtl/spi_master_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//
// Purpose:
//   SPI master with an Avalon-MM slave register interface.
//   Software loads TXDATA, programs CLKDIV, then writes CTRL with the start
//   bit, the slave select and the CPOL/CPHA mode. It then polls STATUS and
//   reads RXDATA. A transfer is DATA_WIDTH bits long and is sent MSB-first.
//
// Register map (word addresses):
//   0 CTRL/STATUS
//       W: [0] start  [1] CPOL  [2] CPHA  [6:4] ss_sel  [8] irq_en
//       R: [0] busy   [1] done  [2] CPOL  [3] CPHA  [6:4] ss_sel  [8] irq_en
//   1 TXDATA  R/W, DATA_WIDTH bits
//   2 RXDATA  RO, zero-extended; reading it clears done
//   3 CLKDIV  R/W, DIV_WIDTH bits; SCLK half-period = CLKDIV+1 clk cycles
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   sclk, mosi, miso SPI clock, data out, data in (miso already synchronous)
//   ss_n[NUM_SS]     active-low slave selects, one-hot-low during a transfer
//   avs_*            Avalon-MM slave: 2-bit address, read/write strobes,
//                    32-bit write data, registered 32-bit read data
//   irq              (only with SPI_MASTER_IRQ_EN) registered done & irq_en
//
// Optional feature:
//   Define SPI_MASTER_IRQ_EN to add the irq output and the CTRL[8] irq_en
//   bit. Without it, CTRL[8] is write-ignored and reads 0.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SS     = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n,
   input  logic [1:0]        avs_address,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata
`ifdef SPI_MASTER_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam int             EDGES     = 2 * DATA_WIDTH;
   localparam int             EDGE_W    = $clog2(EDGES);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } state_t;

   state_t                 state_q;
   logic                   cpol_q, cpol_d;
   logic                   cpha_q, cpha_d;
   logic [2:0]             ss_sel_q, ss_sel_d;
   logic                   done_q, done_d;
   logic [DATA_WIDTH-1:0]  tx_q, tx_d;
   logic [DATA_WIDTH-1:0]  rx_q;
   logic [DIV_WIDTH-1:0]   clkdiv_q, clkdiv_d;
   logic [DIV_WIDTH-1:0]   div_lat_q;
   logic [DIV_WIDTH-1:0]   cnt_q;
   logic [EDGE_W-1:0]      edge_q;
   logic [DATA_WIDTH-1:0]  shift_q;
   logic                   sclk_q;
   logic                   mosi_q;
   logic [NUM_SS-1:0]      ss_n_q;
   logic [31:0]            rdata_q;
   logic [31:0]            rd_mux;
   logic                   irq_en;

   logic                   busy;
   logic                   wr_ok, ctrl_wr, tx_wr, div_wr, rx_rd;
   logic                   start_acc;
   logic                   tick;
   logic                   xfer_end;
   logic                   sample_edge;
   logic                   unused_wdata;

   // Not every write-data bit maps onto a register field.
   assign unused_wdata = ^avs_writedata;

   assign busy     = (state_q != ST_IDLE);
   assign tick     = (cnt_q == div_lat_q);
   assign xfer_end = (state_q == ST_HOLD) && tick;

   // Sampling happens on the leading edge for CPHA=0 and on the trailing edge
   // for CPHA=1; edge_q[0]==0 marks a leading edge.
   assign sample_edge = (edge_q[0] == cpha_q);

`ifdef SPI_MASTER_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q;

   assign irq_en = irq_en_q;
   assign irq    = irq_q;
`else
   assign irq_en = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Bus decode and register next-state
   // ---------------------------------------------------------------------
   always_comb begin
      // A read strobe always wins over a simultaneous write; all writes are
      // dropped while a transfer is running.
      wr_ok   = avs_write && !avs_read && !busy;
      ctrl_wr = wr_ok && (avs_address == 2'd0);
      tx_wr   = wr_ok && (avs_address == 2'd1);
      div_wr  = wr_ok && (avs_address == 2'd3);
      rx_rd   = avs_read && (avs_address == 2'd2);

      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      ss_sel_d = ss_sel_q;
      tx_d     = tx_q;
      clkdiv_d = clkdiv_q;
`ifdef SPI_MASTER_IRQ_EN
      irq_en_d = irq_en_q;
`endif

      if (ctrl_wr) begin
         cpol_d   = avs_writedata[1];
         cpha_d   = avs_writedata[2];
         ss_sel_d = avs_writedata[6:4];
`ifdef SPI_MASTER_IRQ_EN
         irq_en_d = avs_writedata[8];
`endif
      end
      if (tx_wr) begin
         tx_d = avs_writedata[DATA_WIDTH-1:0];
      end
      if (div_wr) begin
         clkdiv_d = avs_writedata[DIV_WIDTH-1:0];
      end

      // A start naming a slave select that does not exist is ignored.
      start_acc = ctrl_wr && avs_writedata[0] &&
                  (int'({29'd0, avs_writedata[6:4]}) < NUM_SS);

      // Completion has priority over a same-cycle RXDATA read.
      done_d = done_q;
      if (xfer_end) begin
         done_d = 1'b1;
      end else if (start_acc || rx_rd) begin
         done_d = 1'b0;
      end

      rd_mux = 32'd0;
      case (avs_address)
         2'd0:    rd_mux = {23'd0, irq_en, 1'b0, ss_sel_q, cpha_q, cpol_q,
                            done_q, busy};
         2'd1:    rd_mux = 32'(tx_q);
         2'd2:    rd_mux = 32'(rx_q);
         default: rd_mux = 32'(clkdiv_q);
      endcase
   end

   // ---------------------------------------------------------------------
   // Register file and registered read data
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         ss_sel_q <= 3'd0;
         done_q   <= 1'b0;
         tx_q     <= '0;
         clkdiv_q <= '0;
         rdata_q  <= 32'd0;
`ifdef SPI_MASTER_IRQ_EN
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
`endif
      end else begin
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         ss_sel_q <= ss_sel_d;
         done_q   <= done_d;
         tx_q     <= tx_d;
         clkdiv_q <= clkdiv_d;
         if (avs_read) begin
            rdata_q <= rd_mux;
         end
`ifdef SPI_MASTER_IRQ_EN
         irq_en_q <= irq_en_d;
         irq_q    <= done_q & irq_en_q;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Transfer FSM and shift engine
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         div_lat_q <= '0;
         cnt_q     <= '0;
         edge_q    <= '0;
         shift_q   <= '0;
         rx_q      <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         ss_n_q    <= '1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Track the CTRL write directly so sclk follows a CPOL change
               // in the same cycle the register does.
               sclk_q <= cpol_d;
               mosi_q <= 1'b0;
               ss_n_q <= '1;
               cnt_q  <= '0;
               edge_q <= '0;
               if (start_acc) begin
                  state_q   <= ST_SETUP;
                  shift_q   <= tx_q;
                  div_lat_q <= clkdiv_q;
                  ss_n_q    <= ~(NUM_SS'(1) << ss_sel_d);
                  // CPHA=0 presents the first bit before the first edge;
                  // CPHA=1 drives it on the leading edge instead.
                  mosi_q    <= cpha_d ? 1'b0 : tx_q[DATA_WIDTH-1];
               end
            end

            ST_SETUP: begin
               if (tick) begin
                  state_q <= ST_SHIFT;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_SHIFT: begin
               if (tick) begin
                  cnt_q  <= '0;
                  sclk_q <= ~sclk_q;
                  edge_q <= edge_q + 1'b1;
                  if (sample_edge) begin
                     shift_q <= {shift_q[DATA_WIDTH-2:0], miso};
                  end else if (edge_q != LAST_EDGE) begin
                     // The final trailing edge (CPHA=0) must not advance mosi.
                     mosi_q <= shift_q[DATA_WIDTH-1];
                  end
                  if (edge_q == LAST_EDGE) begin
                     state_q <= ST_HOLD;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_HOLD: begin
               if (tick) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  ss_n_q  <= '1;
                  mosi_q  <= 1'b0;
                  sclk_q  <= cpol_q;
                  rx_q    <= shift_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sclk         = sclk_q;
   assign mosi         = mosi_q;
   assign ss_n         = ss_n_q;
   assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
//
// Directed bench for spi_master_ctrl (DATA_WIDTH=8, NUM_SS=4, DIV_WIDTH=16).
// Inputs are driven on the falling clk edge and outputs are sampled there.
// A loopback switch ties miso to mosi; otherwise a small slave model shifts
// out a fixed byte on each sclk leading (falling, mode 3) edge.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic [3:0]  ss_n;
   logic [1:0]  avs_address = 2'd0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
`ifdef SPI_MASTER_IRQ_EN
   logic        irq;
`endif

   logic        loop_en  = 1'b1;
   logic        slv_miso = 1'b0;

   int          n_total = 0;
   int          n_bad   = 0;
   int          ss_falls = 0;
   logic        prev_idle = 1'b1;

   assign miso = loop_en ? mosi : slv_miso;

   always #5 clk = ~clk;

   spi_master_ctrl #(
      .DATA_WIDTH (8),
      .NUM_SS     (4),
      .DIV_WIDTH  (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sclk          (sclk),
      .mosi          (mosi),
      .miso          (miso),
      .ss_n          (ss_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata)
`ifdef SPI_MASTER_IRQ_EN
      ,
      .irq           (irq)
`endif
   );

   // Count transfers by the idle-to-selected transition of ss_n.
   always @(negedge clk) begin
      if (prev_idle && (ss_n != 4'hF)) ss_falls++;
      prev_idle = (ss_n == 4'hF);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   // Follows one transfer from the current falling clk edge until ss_n
   // releases, recording cycle count, sclk rising edges and mosi at each one.
   task automatic watch(input int budget, input logic [7:0] slv,
                        output int cyc, output int rises,
                        output logic [7:0] bits, output logic [3:0] ss_seen);
      logic prev;
      int   k;
      cyc     = 0;
      rises   = 0;
      bits    = 8'd0;
      ss_seen = 4'hF;
      k       = 0;
      prev    = sclk;
      while ((ss_n != 4'hF) && (cyc < budget)) begin
         if (ss_seen == 4'hF)      ss_seen = ss_n;
         else if (ss_n != ss_seen) ss_seen = 4'h0;
         if (!prev && sclk) begin
            rises++;
            bits = {bits[6:0], mosi};
         end
         if (prev && !sclk && (k < 8)) begin
            slv_miso = slv[7-k];
            k++;
         end
         prev = sclk;
         cyc++;
         @(negedge clk);
      end
      chk("xfer_ends", {28'd0, ss_n}, 32'h0000_000F);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          cyc, rises, f0;
      logic [7:0]  bits;
      logic [3:0]  ss_seen;

      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // ---- reset while idle with registers programmed ----
      bus_write(2'd1, 32'h0000_005A);
      bus_write(2'd3, 32'h0000_0003);
      bus_write(2'd0, 32'h0000_0002);
      chk("sclk_idle_cpol1", {31'd0, sclk}, 32'd1);
      bus_read(2'd1, rd);
      chk("tx_readback", rd, 32'h0000_005A);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_sclk", {31'd0, sclk}, 32'd0);
      chk("rst_ss_n", {28'd0, ss_n}, 32'h0000_000F);
      chk("rst_readdata", avs_readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a), rd);
         chk($sformatf("rst_reg%0d", a), rd, 32'd0);
      end

      // ---- mode 0 loopback, CLKDIV=1 ----
      loop_en = 1'b1;
      bus_write(2'd3, 32'h0000_0001);
      bus_write(2'd1, 32'h0000_00A5);
      bus_write(2'd0, 32'h0000_0001);
      watch(200, 8'h00, cyc, rises, bits, ss_seen);
      chk("m0_ss_n", {28'd0, ss_seen}, 32'h0000_000E);
      chk("m0_cycles", cyc, 32'd36);
      chk("m0_rises", rises, 32'd8);
      chk("m0_mosi_bits", {24'd0, bits}, 32'h0000_00A5);
      bus_read(2'd0, rd);
      chk("m0_status_done", rd, 32'h0000_0002);
      bus_read(2'd2, rd);
      chk("m0_rxdata", rd, 32'h0000_00A5);
      bus_read(2'd0, rd);
      chk("m0_done_cleared", rd, 32'h0000_0000);

      // ---- mode 3 with external slave, CLKDIV=0 ----
      loop_en = 1'b0;
      bus_write(2'd3, 32'h0000_0000);
      bus_write(2'd0, 32'h0000_0027);
      watch(200, 8'h3C, cyc, rises, bits, ss_seen);
      chk("m3_ss_n", {28'd0, ss_seen}, 32'h0000_000B);
      chk("m3_cycles", cyc, 32'd18);
      chk("m3_mosi_bits", {24'd0, bits}, 32'h0000_00A5);
      chk("m3_sclk_idle", {31'd0, sclk}, 32'd1);
      bus_read(2'd0, rd);
      chk("m3_status", rd, 32'h0000_002E);
      bus_read(2'd2, rd);
      chk("m3_rxdata", rd, 32'h0000_003C);

      // ---- writes while busy are ignored, second start ignored ----
      loop_en = 1'b1;
      bus_write(2'd3, 32'h0000_0003);
      bus_write(2'd1, 32'h0000_0042);
      f0 = ss_falls;
      bus_write(2'd0, 32'h0000_0001);
      bus_write(2'd1, 32'h0000_0011);
      bus_write(2'd3, 32'h0000_0005);
      bus_write(2'd0, 32'h0000_0001);
      bus_read(2'd1, rd);
      chk("busy_tx_kept", rd, 32'h0000_0042);
      bus_read(2'd3, rd);
      chk("busy_div_kept", rd, 32'h0000_0003);
      watch(300, 8'h00, cyc, rises, bits, ss_seen);
      repeat (40) @(negedge clk);
      chk("busy_one_xfer", ss_falls - f0, 32'd1);
      bus_read(2'd2, rd);
      chk("busy_rxdata", rd, 32'h0000_0042);

      // ---- illegal slave select ----
      f0 = ss_falls;
      bus_write(2'd0, 32'h0000_0051);
      repeat (4) @(negedge clk);
      chk("bad_ss_n", {28'd0, ss_n}, 32'h0000_000F);
      chk("bad_ss_no_xfer", ss_falls - f0, 32'd0);
      bus_read(2'd0, rd);
      chk("bad_ss_not_busy", {31'd0, rd[0]}, 32'd0);

      // ---- simultaneous read and write to TXDATA ----
      @(negedge clk);
      avs_address   = 2'd1;
      avs_writedata = 32'h0000_0099;
      avs_read      = 1'b1;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      chk("rw_readdata", avs_readdata, 32'h0000_0042);
      bus_read(2'd1, rd);
      chk("rw_tx_unchanged", rd, 32'h0000_0042);

`ifdef SPI_MASTER_IRQ_EN
      // ---- interrupt on completion ----
      loop_en = 1'b1;
      bus_write(2'd3, 32'h0000_0000);
      bus_write(2'd0, 32'h0000_0101);
      watch(200, 8'h00, cyc, rises, bits, ss_seen);
      chk("irq_lags_done", {31'd0, irq}, 32'd0);
      @(negedge clk);
      chk("irq_set", {31'd0, irq}, 32'd1);
      bus_read(2'd2, rd);
      chk("irq_rxdata", rd, 32'h0000_0042);
      chk("irq_still_set", {31'd0, irq}, 32'd1);
      @(negedge clk);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
`else
      // ---- irq_en bit absent ----
      bus_write(2'd0, 32'h0000_0100);
      bus_read(2'd0, rd);
      chk("irq_en_reads0", rd, 32'h0000_0000);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
